// File: rtl/cpu_pkg.sv
// Shared types and widths for the 32-bit RISC CPU pipeline.
// Holds the ALU opcode enum and the default datapath/register widths.
package cpu_pkg;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b100
   } alu_op_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: ADD/SUB/AND/OR/signed SLT.
// Ports: a_i, b_i operands; op_i opcode; result_o, zero_o (result == 0).
module alu
   import cpu_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [2:0]   op_i,
   output logic [W-1:0] result_o,
   output logic         zero_o
);

   logic [W-1:0] res;

   always_comb begin
      res = '0;
      unique case (op_i)
         ALU_ADD: res = a_i + b_i;
         ALU_SUB: res = a_i - b_i;
         ALU_AND: res = a_i & b_i;
         ALU_OR:  res = a_i | b_i;
         ALU_SLT: res = {{(W-1){1'b0}},
                         $signed(a_i) < $signed(b_i)};
         // Undefined opcodes give 0, hence zero_o = 1.
         default: res = '0;
      endcase
   end

   assign result_o = res;
   assign zero_o   = (res == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, ALU, BEQ resolution, output register.
// Ports: ID-side in_* with in_valid/in_ready, MEM-side out_* with
// out_valid/out_ready, br_taken/br_target, flush, retired counter.
module ex_stage
#(
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int REG_W  = cpu_pkg::REG_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic [REG_W-1:0]  in_rs1,
   input  logic [REG_W-1:0]  in_rs2,
   input  logic [1:0]        in_fwd_en,
   input  logic [2:0]        in_alu_op,
   input  logic [REG_W-1:0]  in_rd,
   input  logic              in_wen,
   input  logic              in_branch,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [DATA_W-1:0] in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic              out_zero,
   output logic [REG_W-1:0]  out_rd,
   output logic              out_wen,
   output logic              br_taken,
   output logic [DATA_W-1:0] br_target,
   output logic [31:0]       retired
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              zero_q, zero_d;
   logic [REG_W-1:0]  rd_q, rd_d;
   logic              wen_q, wen_d;
   logic              br_q, br_d;
   logic [DATA_W-1:0] tgt_q, tgt_d;
   logic [31:0]       ret_q, ret_d;

   logic              accept, hs;
   logic              fwd_a, fwd_b;
   logic [DATA_W-1:0] opa, opb, alu_res;
   logic              alu_zero;

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready && !flush;
   assign hs       = valid_q && out_ready;

   // The held result is still a legal source while it drains to MEM.
   assign fwd_a = in_fwd_en[0] && valid_q && wen_q &&
                  (rd_q != '0) && (rd_q == in_rs1);
   assign fwd_b = in_fwd_en[1] && valid_q && wen_q &&
                  (rd_q != '0) && (rd_q == in_rs2);

   assign opa = fwd_a ? result_q : in_a;
   assign opb = fwd_b ? result_q : in_b;

   alu #(.W(DATA_W)) u_alu (
      .a_i      (opa),
      .b_i      (opb),
      .op_i     (in_alu_op),
      .result_o (alu_res),
      .zero_o   (alu_zero)
   );

   always_comb begin
      valid_d  = valid_q;
      result_d = result_q;
      zero_d   = zero_q;
      rd_d     = rd_q;
      wen_d    = wen_q;
      br_d     = br_q;
      tgt_d    = tgt_q;
      ret_d    = ret_q;
      if (flush) begin
         valid_d = 1'b0;
         br_d    = 1'b0;
      end else begin
         if (hs) begin
            valid_d = 1'b0;
            ret_d   = ret_q + 32'd1;
         end
         if (accept) begin
            valid_d  = 1'b1;
            result_d = alu_res;
            zero_d   = alu_zero;
            rd_d     = in_rd;
            wen_d    = in_wen && !in_branch;
            br_d     = in_branch && alu_zero;
            tgt_d    = in_pc + in_imm;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b0;
         rd_q     <= '0;
         wen_q    <= 1'b0;
         br_q     <= 1'b0;
         tgt_q    <= '0;
         ret_q    <= '0;
      end else begin
         valid_q  <= valid_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         rd_q     <= rd_d;
         wen_q    <= wen_d;
         br_q     <= br_d;
         tgt_q    <= tgt_d;
         ret_q    <= ret_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_result = result_q;
   assign out_zero   = zero_q;
   assign out_rd     = rd_q;
   assign out_wen    = wen_q;
   assign br_taken   = br_q;
   assign br_target  = tgt_q;
   assign retired    = ret_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed scenarios plus random traffic.
// Driver predicts each accepted instruction; monitor pops on output.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready;
   logic [31:0] in_a, in_b, in_pc, in_imm;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic [1:0]  in_fwd_en;
   logic [2:0]  in_alu_op;
   logic        in_wen, in_branch;
   logic        out_valid, out_ready, out_zero, out_wen, br_taken;
   logic [31:0] out_result, br_target, retired;
   logic [4:0]  out_rd;

   ex_stage dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b),
      .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_fwd_en(in_fwd_en), .in_alu_op(in_alu_op),
      .in_rd(in_rd), .in_wen(in_wen), .in_branch(in_branch),
      .in_pc(in_pc), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_zero(out_zero),
      .out_rd(out_rd), .out_wen(out_wen),
      .br_taken(br_taken), .br_target(br_target),
      .retired(retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic        zero;
      logic [4:0]  rd;
      logic        wen;
      logic        bt;
      logic [31:0] tg;
   } exp_t;

   exp_t        q[$];
   exp_t        held;
   bit          mv;
   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_ret;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(logic [2:0] op,
                                           logic [31:0] a,
                                           logic [31:0] b);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   // Drive one cycle starting just after a rising edge; returns #1
   // after the next rising edge with the model updated.
   task automatic drive(bit v, logic [31:0] a, logic [31:0] b,
                        logic [4:0] rs1, logic [4:0] rs2,
                        logic [1:0] fe, logic [2:0] op,
                        logic [4:0] rd, bit wen, bit br,
                        logic [31:0] pc, logic [31:0] imm,
                        bit ordy, bit fl);
      bit          acc, pend;
      logic [31:0] fa, fb, r;
      exp_t        e;
      in_valid = v; in_a = a; in_b = b; in_rs1 = rs1; in_rs2 = rs2;
      in_fwd_en = fe; in_alu_op = op; in_rd = rd; in_wen = wen;
      in_branch = br; in_pc = pc; in_imm = imm;
      out_ready = ordy; flush = fl;
      #1;
      chk("in_ready", {31'd0, in_ready}, {31'd0, (!mv || ordy)});
      acc  = v && (!mv || ordy) && !fl;
      pend = mv && held.wen && held.rd != 5'd0;
      fa = (fe[0] && pend && held.rd == rs1) ? held.res : a;
      fb = (fe[1] && pend && held.rd == rs2) ? held.res : b;
      r  = ref_alu(op, fa, fb);
      if (acc) begin
         e.res = r; e.zero = (r == 32'd0); e.rd = rd;
         e.wen = wen && !br; e.bt = br && (r == 32'd0);
         e.tg = pc + imm;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      if (fl) mv = 1'b0;
      else if (acc) begin mv = 1'b1; held = e; end
      else if (mv && ordy) mv = 1'b0;
   endtask

   task automatic idle(bit ordy);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ordy, 0);
   endtask

   // Monitor: an item leaves the stage on handshake or flush.
   initial begin
      exp_ret = 32'd0;
      forever begin
         @(negedge clk);
         if (!rst_n) exp_ret = 32'd0;
         else begin
            chk("retired", retired, exp_ret);
            if (out_valid && (out_ready || flush)) begin
               if (q.size() == 0) begin
                  chk("unexpected_out", 32'd1, 32'd0);
               end else begin
                  exp_t e;
                  e = q.pop_front();
                  chk("out_result", out_result, e.res);
                  chk("out_zero", {31'd0, out_zero}, {31'd0, e.zero});
                  chk("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
                  chk("out_wen", {31'd0, out_wen}, {31'd0, e.wen});
                  chk("br_taken", {31'd0, br_taken}, {31'd0, e.bt});
                  if (e.bt) chk("br_target", br_target, e.tg);
               end
               if (out_ready && !flush) exp_ret = exp_ret + 32'd1;
            end
         end
      end
   end

   initial begin
      logic [31:0] r0;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_a = 0; in_b = 0; in_rs1 = 0; in_rs2 = 0; in_fwd_en = 0;
      in_alu_op = 0; in_rd = 0; in_wen = 0; in_branch = 0;
      in_pc = 0; in_imm = 0; mv = 1'b0;
      #12;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_retired", retired, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Back-to-back forward
      drive(1, 5, 7, 0, 0, 2'b00, 3'd0, 3, 1, 0, 0, 0, 1, 0);
      chk("b2b_res0", out_result, 32'd12);
      chk("b2b_zero0", {31'd0, out_zero}, 32'd0);
      drive(1, 100, 12, 3, 0, 2'b01, 3'd1, 6, 1, 0, 0, 0, 1, 0);
      chk("b2b_res1", out_result, 32'd0);
      chk("b2b_zero1", {31'd0, out_zero}, 32'd1);
      chk("b2b_valid", {31'd0, out_valid}, 32'd1);
      idle(1);

      // Stall hold
      drive(1, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 0, 0, 3'd2, 7, 1, 0,
            0, 0, 1, 0);
      r0 = retired;
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 1, 0, 0, 0, 3'd0, 1, 1, 0, 0, 0, 0, 0);
         chk("stall_res", out_result, 32'h00F000F0);
         chk("stall_ret", retired, r0);
      end
      idle(1);
      chk("release_ret", retired, r0 + 32'd1);

      // BEQ taken / not taken
      drive(1, 9, 9, 0, 0, 0, 3'd1, 5, 1, 1, 32'h100, 32'h20, 1, 0);
      chk("beq_taken", {31'd0, br_taken}, 32'd1);
      chk("beq_target", br_target, 32'h120);
      chk("beq_wen", {31'd0, out_wen}, 32'd0);
      drive(1, 9, 8, 0, 0, 0, 3'd1, 5, 1, 1, 32'h100, 32'h20, 1, 0);
      chk("bne_taken", {31'd0, br_taken}, 32'd0);

      // rd=0 producer, then fwd_en=00 with matching index
      drive(1, 40, 2, 0, 0, 0, 3'd0, 0, 1, 0, 0, 0, 1, 0);
      drive(1, 77, 1, 0, 0, 2'b11, 3'd0, 4, 1, 0, 0, 0, 1, 0);
      chk("rd0_res", out_result, 32'd78);
      drive(1, 20, 30, 4, 4, 2'b00, 3'd0, 8, 1, 0, 0, 0, 1, 0);
      chk("imm_res", out_result, 32'd50);

      // Flush collision on a held taken branch
      drive(1, 3, 3, 0, 0, 0, 3'd1, 0, 0, 1, 4, 4, 0, 0);
      r0 = retired;
      drive(1, 1, 2, 0, 0, 0, 3'd0, 9, 1, 0, 0, 0, 1, 1);
      chk("flush_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_br", {31'd0, br_taken}, 32'd0);
      chk("flush_ret", retired, r0);

      // Undefined op, signed SLT
      drive(1, 5, 6, 0, 0, 0, 3'd7, 2, 1, 0, 0, 0, 1, 0);
      chk("undef_res", out_result, 32'd0);
      chk("undef_zero", {31'd0, out_zero}, 32'd1);
      drive(1, 32'hFFFFFFFF, 1, 0, 0, 0, 3'd4, 2, 1, 0, 0, 0, 1, 0);
      chk("slt_res", out_result, 32'd1);
      idle(1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         bit br;
         logic [2:0] op;
         br = ($urandom_range(0, 5) == 0);
         op = br ? 3'd1 : 3'($urandom_range(0, 7));
         drive($urandom_range(0, 3) != 0,
               ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3))
                                           : $urandom,
               ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3))
                                           : $urandom,
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               2'($urandom_range(0, 3)), op,
               5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, br,
               $urandom, $urandom,
               $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
      end
      idle(1);

      // Reset mid-stall
      drive(1, 11, 22, 0, 0, 0, 3'd0, 3, 1, 1, 32'h40, 32'h4, 0, 0);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst2_valid", {31'd0, out_valid}, 32'd0);
      chk("rst2_result", out_result, 32'd0);
      chk("rst2_zero", {31'd0, out_zero}, 32'd0);
      chk("rst2_rd", {27'd0, out_rd}, 32'd0);
      chk("rst2_wen", {31'd0, out_wen}, 32'd0);
      chk("rst2_br", {31'd0, br_taken}, 32'd0);
      chk("rst2_tgt", br_target, 32'd0);
      chk("rst2_ret", retired, 32'd0);
      q.delete();
      mv = 1'b0;
      #4 rst_n = 1'b1;
      @(posedge clk); #1;
      drive(1, 2, 3, 0, 0, 0, 3'd0, 1, 1, 0, 0, 0, 1, 0);
      chk("post_rst_res", out_result, 32'd5);

      for (int i = 0; i < 10 && q.size() != 0; i++) idle(1);
      idle(1);
      chk("drain", q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute pipeline stage of the 32-bit RISC CPU. It accepts decoded operands from the ID stage and runs them through the existing `alu` (ADD/SUB/AND/OR/SLT, 3-bit `alu_op`). It forwards its own registered result to a dependent next instruction, resolves BEQ branches from the ALU `zero` flag, and presents a registered result to the MEM stage through a valid/ready handshake.

## Interface
- `DATA_W`, 32, datapath width
- `REG_W`, 5, register index width
- `clk` in 1: clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `flush` in 1: synchronous kill of the held result and of any same-cycle input
- `in_valid` in 1: ID presents an instruction
- `in_ready` out 1: stage accepts this cycle
- `in_a`, `in_b` in DATA_W: operands from the register file or immediate
- `in_rs1`, `in_rs2` in REG_W: source indices for `in_a` and `in_b`
- `in_fwd_en` in 2: bit0 allows forwarding onto a, bit1 onto b (0 when the operand is an immediate)
- `in_alu_op` in 3: ALU operation, passed straight to `alu`
- `in_rd` in REG_W: destination register
- `in_wen` in 1: writes `rd`
- `in_branch` in 1: BEQ (decoder guarantees `in_alu_op`=SUB)
- `in_pc`, `in_imm` in DATA_W: branch base and offset
- `out_valid` out 1; `out_ready` in 1: MEM handshake
- `out_result` out DATA_W; `out_zero` out 1: registered ALU outputs
- `out_rd` out REG_W; `out_wen` out 1: registered destination
- `br_taken` out 1; `br_target` out DATA_W: registered branch resolution
- `retired` out 32: count of completed output handshakes

## Operation
**Pipeline handshake**
- Single output register.
- `in_ready = !out_valid || out_ready`.
- Accept when `in_valid && in_ready && !flush`.
- Output handshake when `out_valid && out_ready`.

**Forwarding of operand a**
- Substitute `out_result` for `in_a` when all of these hold: `in_fwd_en[0]`, `out_valid`, `out_wen`, `out_rd != 0`, and `out_rd == in_rs1`.
- Operand b uses the same rule with `in_fwd_en[1]` and `in_rs2`.
- Forwarding uses the currently held output, including on a cycle where that output is being consumed.

**Capture on accept**
- `out_result`/`out_zero` take the ALU outputs for the forwarded operands.
- `out_rd` takes `in_rd`.
- `out_wen` takes `in_wen && !in_branch`.
- `br_taken` takes `in_branch && alu zero`.
- `br_target` takes `in_pc + in_imm`, mod 2^32, wraps silently.

**ALU behaviour**
- Undefined `alu_op` (101/110/111) yields result 0 and zero 1; the stage registers these unchanged.
- SLT is signed.

**Register updates without an accept**
- Output handshake without a new accept: `out_valid` goes to 0; the data registers hold their values.
- No handshake: everything holds, so the output is stable while `out_valid && !out_ready`.

**Flush**
- Next cycle `out_valid`=0 and `br_taken`=0.
- Flush overrides a same-cycle accept and a same-cycle output handshake; `retired` does not count a flushed cycle.

**Retired counter**
- Increments by 1 on each output handshake.
- Wraps from 0xFFFFFFFF to 0.

## Timing
- Latency 1 cycle from accept to `out_valid`; throughput 1 instruction per cycle while `out_ready`=1.
- `in_ready` is combinational from `out_valid`/`out_ready`; every other output is registered.
- Reset values (immediate on `rst_n` low, regardless of clock): `out_valid`=0, `out_result`=0, `out_zero`=0, `out_rd`=0, `out_wen`=0, `br_taken`=0, `br_target`=0, `retired`=0.
- Reset while stalled discards the held instruction; the first accept is possible on the first edge after `rst_n` rises.
- Taken branch: `br_taken` is visible in the same cycle as its `out_valid`. The CPU asserts `flush` to this stage on the following edge for wrong-path work; this stage never self-flushes.

## Structure
- Shared package `cpu_pkg` holds:
  - `alu_op_t` with `ALU_ADD`=000, `ALU_SUB`=001, `ALU_AND`=010, `ALU_OR`=011, `ALU_SLT`=100
  - `DATA_W`/`REG_W` defaults
- Sub-module: the existing `alu`, instantiated once and unchanged.
- Forwarding muxes, branch adder and output register are local to `ex_stage`.

## Test plan
- **Back-to-back forward:**
  - Cycle 0: ADD a=5, b=7, rd=3, wen.
  - Cycle 1: SUB rs1=3 (fwd), b=12.
  - Required: `out_result` 12 then 0, `out_zero` 0 then 1, no bubble.
- **Stall hold:** `out_ready`=0 for 3 cycles after an AND of 0xF0F0F0F0 & 0x0FF00FF0. Required: `out_result` stays 0x00F000F0, `in_ready`=0, `retired` unchanged; then it increments by 1 on release.
- **BEQ taken/not:**
  - pc=0x100, imm=0x20, a=b=9: `br_taken`=1, `br_target`=0x120, `out_wen`=0.
  - a=9, b=8: `br_taken`=0.
- **rd=0 / immediate:** producer rd=0 followed by consumer rs1=0 reads `in_a` unforwarded; with `in_fwd_en`=00 no forwarding occurs even when indices match.
- **Flush collision:** `flush`, `in_valid` and `out_ready` all high in one cycle. Required: next cycle `out_valid`=0, `retired` unchanged.
- **Undefined op, SLT, reset:**
  - op 111: `out_result` 0, `out_zero` 1.
  - SLT -1 < 1: `out_result` 1.
  - `rst_n` low mid-stall: all outputs 0 immediately.
